// File: rtl/regfile_2w2r.sv
// rtl/regfile_2w2r.sv - two-write two-read register file with collision flag (optional macro REGFILE_BYPASS_EN)
module regfile_2w2r #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int ZERO_REG = 0,
   localparam int ADDR_W  = $clog2(DEPTH)
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              WR_A,
   input  logic [ADDR_W-1:0] Addr_WA,
   input  logic [DATA_W-1:0] DIN_A,
   input  logic              WR_B,
   input  logic [ADDR_W-1:0] Addr_WB,
   input  logic [DATA_W-1:0] DIN_B,
   input  logic              Clear,
   input  logic [ADDR_W-1:0] Addr_A,
   input  logic [ADDR_W-1:0] Addr_B,
   output logic [DATA_W-1:0] Out_A,
   output logic [DATA_W-1:0] Out_B,
   output logic              Collision
);

   // One extra bit so the range check cannot wrap when DEPTH is a power of 2
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_a_ok;
   logic              wr_b_ok;
   logic              coll_next;

   // An address is usable if it is inside the array and is not the hardwired zero register
   function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
      logic ok;
      ok = ({1'b0, addr} < DEPTH_X);
      if ((ZERO_REG != 0) && (addr == '0))
         ok = 1'b0;
      return ok;
   endfunction

   // Read mux: out-of-range and zero-register reads give 0; optional forwarding of write data
   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
      logic [DATA_W-1:0] rd;
      rd = '0;
      if (addr_ok(addr)) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_W'(i))
               rd = mem[i];
         end
      end
`ifdef REGFILE_BYPASS_EN
      if (!Clear) begin
         if (wr_b_ok && (Addr_WB == addr))
            rd = DIN_B;
         else if (wr_a_ok && (Addr_WA == addr))
            rd = DIN_A;
      end
`endif
      return rd;
   endfunction

   assign wr_a_ok   = WR_A && addr_ok(Addr_WA);
   assign wr_b_ok   = WR_B && addr_ok(Addr_WB);
   assign coll_next = !Clear && wr_a_ok && wr_b_ok && (Addr_WA == Addr_WB);

   // Register array and collision flag; Clear beats writes, port B beats port A
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
         Collision <= 1'b0;
      end else begin
         Collision <= coll_next;
         for (int i = 0; i < DEPTH; i++) begin
            if (Clear)
               mem[i] <= '0;
            else if (wr_b_ok && (Addr_WB == ADDR_W'(i)))
               mem[i] <= DIN_B;
            else if (wr_a_ok && (Addr_WA == ADDR_W'(i)))
               mem[i] <= DIN_A;
         end
      end
   end

   assign Out_A = read_port(Addr_A);
   assign Out_B = read_port(Addr_B);

endmodule
